// File: rtl/seg7_capture.sv
// Seven-segment capture: samples a multiplexed 4-digit display bus, waits for a
// pattern to be stable for STABLE samples, decodes it and assembles a 16-bit value.
module seg7_capture #(
  parameter int unsigned STABLE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg,
  input  logic [3:0]  dig_en,
  output logic [15:0] value,
  output logic [3:0]  valid,
  output logic        upd,
  output logic [1:0]  upd_digit,
  output logic        err,
  output logic        frame_done
);

  localparam int unsigned CW = $clog2(STABLE + 1);

  typedef enum logic [1:0] {IDLE, TRACK, ACCEPT, HOLD} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [6:0]     s_seg_q;
  logic [3:0]     s_dig_q;
  logic [15:0]    value_q, value_d;
  logic [3:0]     valid_q, valid_d;
  logic           upd_q, upd_d;
  logic [1:0]     upd_digit_q, upd_digit_d;
  logic           err_q, err_d;
  logic           frame_done_q, frame_done_d;

  logic           elig, same;
  logic [3:0]     nib;
  logic           dec_ok;
  logic [1:0]     idx;

  // The sample being captured this edge is judged against the one already held,
  // so the first stable sample counts at the same edge it is registered.
  assign elig = (dig_en != 4'd0) && ((dig_en & (dig_en - 4'd1)) == 4'd0) && (seg != 7'd0);
  assign same = ({seg, dig_en} == {s_seg_q, s_dig_q});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s_seg_q <= '0;
      s_dig_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s_seg_q <= seg;
      s_dig_q <= dig_en;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (elig) begin
          state_d = TRACK;
          cnt_d   = CW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      TRACK: begin
        if (!elig) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          if (!same)                   cnt_d = CW'(1);
          else if (cnt_q != CW'(STABLE)) cnt_d = cnt_q + CW'(1);
          if (cnt_d == CW'(STABLE)) state_d = ACCEPT;
        end
      end
      ACCEPT: state_d = HOLD;
      HOLD: begin
        if (!same) begin
          if (elig) begin
            state_d = TRACK;
            cnt_d   = CW'(1);
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    nib    = '0;
    dec_ok = 1'b1;
    case (s_seg_q)
      7'h7E: nib = 4'h0;
      7'h30: nib = 4'h1;
      7'h6D: nib = 4'h2;
      7'h79: nib = 4'h3;
      7'h33: nib = 4'h4;
      7'h5B: nib = 4'h5;
      7'h5F: nib = 4'h6;
      7'h70: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h7B: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h1F: nib = 4'hB;
      7'h4E: nib = 4'hC;
      7'h3D: nib = 4'hD;
      7'h4F: nib = 4'hE;
      7'h47: nib = 4'hF;
      default: dec_ok = 1'b0;
    endcase
    case (s_dig_q)
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
  end

  // All-ones valid lives exactly one cycle: that cycle produces frame_done and
  // clears valid; acceptances are spaced too far apart to collide with it.
  always_comb begin
    value_d      = value_q;
    valid_d      = (&valid_q) ? '0 : valid_q;
    upd_d        = 1'b0;
    upd_digit_d  = upd_digit_q;
    err_d        = 1'b0;
    frame_done_d = &valid_q;
    if (state_q == ACCEPT) begin
      if (dec_ok) begin
        value_d[{idx, 2'b00} +: 4] = nib;
        valid_d[idx]               = 1'b1;
        upd_d                      = 1'b1;
        upd_digit_d                = idx;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q      <= '0;
      valid_q      <= '0;
      upd_q        <= 1'b0;
      upd_digit_q  <= '0;
      err_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      value_q      <= value_d;
      valid_q      <= valid_d;
      upd_q        <= upd_d;
      upd_digit_q  <= upd_digit_d;
      err_q        <= err_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign value      = value_q;
  assign valid      = valid_q;
  assign upd        = upd_q;
  assign upd_digit  = upd_digit_q;
  assign err        = err_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: run-length reference model checked every cycle, plus a
// vector table and hand sequences for latency, frame completion and mid-run reset.
module tb_seg7_capture;
  localparam int unsigned STABLE = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg = '0;
  logic [3:0]  dig_en = '0;
  logic [15:0] value;
  logic [3:0]  valid;
  logic        upd;
  logic [1:0]  upd_digit;
  logic        err;
  logic        frame_done;

  always #5 clk = ~clk;

  seg7_capture #(.STABLE(STABLE)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .dig_en(dig_en),
    .value(value), .valid(valid), .upd(upd), .upd_digit(upd_digit),
    .err(err), .frame_done(frame_done)
  );

  int unsigned total = 0;
  int unsigned bad = 0;

  logic [6:0] segtab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                              7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Reference model: length of the current run of identical eligible samples,
  // a one-sample swallow after an acceptance, then blocking until the input changes.
  logic [10:0] prev;
  int unsigned run;
  bit          skip, blocked, acc_pend, fd_pend;
  logic [10:0] pend_pat;
  logic [15:0] m_value;
  logic [3:0]  m_valid;
  logic        m_upd, m_err, m_fd;
  logic [1:0]  m_digit;

  task automatic model_reset();
    prev = '0; run = 0; skip = 0; blocked = 0; acc_pend = 0; fd_pend = 0; pend_pat = '0;
    m_value = '0; m_valid = '0; m_upd = 0; m_err = 0; m_fd = 0; m_digit = '0;
  endtask

  task automatic model_step(input logic [10:0] x);
    int k;
    int dg;
    int ones;
    bit elig;
    m_upd = 0; m_err = 0; m_fd = 0;
    if (fd_pend) begin m_fd = 1; m_valid = '0; fd_pend = 0; end
    if (acc_pend) begin
      acc_pend = 0;
      k = -1;
      for (int i = 0; i < 16; i++) if (segtab[i] == pend_pat[10:4]) k = i;
      dg = 0;
      for (int i = 0; i < 4; i++) if (pend_pat[i]) dg = i;
      if (k >= 0) begin
        m_value[4*dg +: 4] = 4'(k);
        m_valid[dg] = 1'b1;
        m_upd = 1;
        m_digit = 2'(dg);
        if (m_valid == 4'hF) fd_pend = 1;
      end else begin
        m_err = 1;
      end
    end
    ones = 0;
    for (int i = 0; i < 4; i++) ones += int'(x[i]);
    elig = (ones == 1) && (x[10:4] != 0);
    if (skip) begin
      skip = 0; blocked = 1;
    end else if (blocked) begin
      if (x != prev) begin blocked = 0; run = elig ? 1 : 0; end
    end else begin
      if (!elig) run = 0;
      else if (run > 0 && x == prev) run++;
      else run = 1;
      if (run == STABLE) begin acc_pend = 1; pend_pat = x; skip = 1; end
    end
    prev = x;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".value"}, 32'(value), 32'(m_value));
    check({tag, ".valid"}, 32'(valid), 32'(m_valid));
    check({tag, ".upd"}, 32'(upd), 32'(m_upd));
    check({tag, ".upd_digit"}, 32'(upd_digit), 32'(m_digit));
    check({tag, ".err"}, 32'(err), 32'(m_err));
    check({tag, ".frame_done"}, 32'(frame_done), 32'(m_fd));
  endtask

  int unsigned edge_no = 0;
  int unsigned n_upd, n_err, n_fd;
  int unsigned upd_edge, fd_edge;
  logic [1:0]  upd_dig_seen;

  task automatic tick();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step({seg, dig_en});
    #1;
    check_outputs("model");
    if (upd) begin n_upd++; upd_edge = edge_no; upd_dig_seen = upd_digit; end
    if (err) n_err++;
    if (frame_done) begin n_fd++; fd_edge = edge_no; end
    edge_no++;
  endtask

  task automatic hold(input logic [6:0] s, input logic [3:0] d, input int unsigned n);
    seg = s; dig_en = d;
    n_upd = 0; n_err = 0; n_fd = 0;
    edge_no = 0; upd_edge = 999; fd_edge = 999;
    for (int unsigned c = 0; c < n; c++) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    for (int unsigned c = 0; c < 2; c++) tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [6:0]  seg;
    logic [3:0]  dig;
    int unsigned cyc;
    int unsigned n_upd;
    int unsigned n_err;
    int unsigned n_fd;
    logic [15:0] value;
    logic [3:0]  valid;
  } vec_t;

  vec_t vt [12];

  initial begin
    vt[0]  = '{7'h00, 4'h0, 3,  0, 0, 0, 16'h0000, 4'h0};
    vt[1]  = '{7'h6D, 4'h4, 10, 1, 0, 0, 16'h0200, 4'h4};
    vt[2]  = '{7'h00, 4'h0, 2,  0, 0, 0, 16'h0200, 4'h4};
    vt[3]  = '{7'h30, 4'h1, 3,  0, 0, 0, 16'h0200, 4'h4};
    vt[4]  = '{7'h00, 4'h0, 2,  0, 0, 0, 16'h0200, 4'h4};
    vt[5]  = '{7'h01, 4'h8, 6,  0, 1, 0, 16'h0200, 4'h4};
    vt[6]  = '{7'h7E, 4'hC, 6,  0, 0, 0, 16'h0200, 4'h4};
    vt[7]  = '{7'h00, 4'h0, 2,  0, 0, 0, 16'h0200, 4'h4};
    vt[8]  = '{7'h30, 4'h1, 6,  1, 0, 0, 16'h0201, 4'h5};
    vt[9]  = '{7'h6D, 4'h2, 6,  1, 0, 0, 16'h0221, 4'h7};
    vt[10] = '{7'h79, 4'h4, 6,  1, 0, 0, 16'h0321, 4'h7};
    vt[11] = '{7'h33, 4'h8, 6,  1, 0, 1, 16'h4321, 4'h0};

    // Reset with random inputs: everything stays at zero.
    model_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seg = 7'($urandom); dig_en = 4'($urandom);
      tick();
    end
    check("rst.value", 32'(value), 32'h0);
    check("rst.valid", 32'(valid), 32'h0);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      hold(vt[i].seg, vt[i].dig, vt[i].cyc);
      check($sformatf("vec%0d.n_upd", i), n_upd, vt[i].n_upd);
      check($sformatf("vec%0d.n_err", i), n_err, vt[i].n_err);
      check($sformatf("vec%0d.n_fd", i), n_fd, vt[i].n_fd);
      check($sformatf("vec%0d.value", i), 32'(value), 32'(vt[i].value));
      check($sformatf("vec%0d.valid", i), 32'(valid), 32'(vt[i].valid));
    end

    // Single digit latency: upd after edge STABLE, exactly once.
    do_reset();
    hold(7'h6D, 4'b0100, 10);
    check("single.upd_edge", upd_edge, STABLE);
    check("single.n_upd", n_upd, 1);
    check("single.digit", 32'(upd_dig_seen), 32'd2);
    check("single.value", 32'(value), 32'h0200);
    check("single.valid", 32'(valid), 32'h4);

    // Full frame: frame_done one cycle after the fourth upd.
    do_reset();
    hold(7'h30, 4'b0001, 6);
    hold(7'h6D, 4'b0010, 6);
    hold(7'h79, 4'b0100, 6);
    hold(7'h33, 4'b1000, 6);
    check("frame.n_fd", n_fd, 1);
    check("frame.fd_edge", fd_edge, upd_edge + 1);
    check("frame.value", 32'(value), 32'h4321);
    check("frame.valid", 32'(valid), 32'h0);

    // Reset at cnt=3 of a 5B run, then a fresh run is needed.
    do_reset();
    hold(7'h5B, 4'b0001, 3);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("midrst");
    tick(); tick();
    rst_n = 1'b1;
    hold(7'h5B, 4'b0001, STABLE);
    check("midrst.no_upd", n_upd, 0);
    check("midrst.value0", 32'(value), 32'h0);
    tick();
    check("midrst.upd", 32'(upd), 32'h1);
    check("midrst.value", 32'(value), 32'h0005);

    // Randomized runs against the model.
    for (int r = 0; r < 400; r++) begin
      logic [6:0] s;
      logic [3:0] d;
      int unsigned pick;
      pick = $urandom_range(0, 9);
      if (pick < 6) s = segtab[$urandom_range(0, 15)];
      else if (pick < 8) s = 7'($urandom);
      else s = 7'h00;
      pick = $urandom_range(0, 9);
      if (pick < 7) d = 4'b0001 << $urandom_range(0, 3);
      else d = 4'($urandom);
      if ($urandom_range(0, 59) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("rand.rst");
        tick();
        rst_n = 1'b1;
      end
      hold(s, d, $urandom_range(1, 8));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
